// File: rtl/sa_seq.sv
// sa_seq: sequencer for the NxN int8 output-stationary systolic array.
// Accepts one K-step of operands per cycle (A column + B row) over
// valid/ready. It clears the array accumulators, applies the diagonal input
// skew, counts the drain time and pulses done when the array's c outputs
// hold the final C = A*B.
// Optional feature macro: SA_SEQ_PERF_EN adds the saturating performance
// counters perf_busy_cyc and perf_stall_cyc.
// Reset: rst is asynchronous and active low.

module sa_seq #(
  parameter int N      = 8,   // array dimension
  parameter int DW     = 8,   // operand width per lane
  parameter int KW     = 8,   // width of k_len
  parameter int PE_LAT = 1    // extra cycles from sa input to accumulator update
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  output logic            busy,
  output logic            done,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] a_col,
  input  logic [N*DW-1:0] b_row,
  output logic            sa_rst,
  output logic [N*DW-1:0] sa_a,
  output logic [N*DW-1:0] sa_b
`ifdef SA_SEQ_PERF_EN
  ,
  output logic [31:0]     perf_busy_cyc,
  output logic [31:0]     perf_stall_cyc
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Cycles from the last step entering the skew stage until the
  // bottom-right PE has accumulated it.
  localparam int DRAIN_CYC = 2*N - 2 + PE_LAT;
  localparam int DCW       = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_len_q;     // job length, frozen at accepted start
  logic [KW-1:0]   k_cnt;       // handshakes taken in this job
  logic [DCW-1:0]  drain_cnt;   // cycles spent in DRAIN
  logic            start_acc;
  logic            hs;
  logic            last_step;
  logic            drain_last;
  logic [N*DW-1:0] step_a;
  logic [N*DW-1:0] step_b;

  // start only counts in IDLE; mid-job pulses and k_len changes are ignored.
  assign start_acc  = start && (state_q == S_IDLE);
  assign hs         = in_valid && (state_q == S_FEED);
  assign last_step  = (k_cnt == k_len_q - 1'b1);
  assign drain_last = (drain_cnt == DCW'(DRAIN_CYC - 1));

  // A cycle without a handshake feeds an all-zero step (bubble), which adds
  // nothing to any accumulator but keeps the diagonal alignment intact.
  assign step_a = hs ? a_col : '0;
  assign step_b = hs ? b_row : '0;

  // State register.
  // NOTE: clocked state is always written with non-blocking assignments so
  // every flop samples values from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state and status decode.
  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    done     = 1'b0;
    in_ready = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        busy    = 1'b1;
        state_d = (k_len_q == '0) ? S_DONE : S_FEED;
      end
      S_FEED: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (hs && last_step) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_last) state_d = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Job length capture, step counter and drain timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_len_q   <= '0;
      k_cnt     <= '0;
      drain_cnt <= '0;
    end else begin
      if (start_acc) begin
        k_len_q <= k_len;
        k_cnt   <= '0;
      end else if (hs) begin
        k_cnt <= k_cnt + 1'b1;
      end
      if (state_q == S_DRAIN) drain_cnt <= drain_cnt + 1'b1;
      else                    drain_cnt <= '0;
    end
  end

  // Accumulator clear: low for the whole CLEAR cycle and during reset, high
  // otherwise, so C stays readable in IDLE after done. Registered from the
  // next state to keep the array's clear glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sa_rst <= 1'b0;
    else      sa_rst <= (state_d != S_CLEAR);
  end

  // Diagonal skew: lane i of a and lane i of b pass through i+1 registers,
  // the last of which drives sa_a / sa_b directly.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [DW-1:0] a_pipe [0:gi];
    logic [DW-1:0] b_pipe [0:gi];

    // Per-lane shift registers.
    // NOTE: these small register arrays are reset explicitly so an aborted
    // job leaves no stale operands to leak into the next one's accumulation.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int s = 0; s <= gi; s++) begin
          a_pipe[s] <= '0;
          b_pipe[s] <= '0;
        end
      end else begin
        a_pipe[0] <= step_a[gi*DW +: DW];
        b_pipe[0] <= step_b[gi*DW +: DW];
        for (int s = 1; s <= gi; s++) begin
          a_pipe[s] <= a_pipe[s-1];
          b_pipe[s] <= b_pipe[s-1];
        end
      end
    end

    assign sa_a[gi*DW +: DW] = a_pipe[gi];
    assign sa_b[gi*DW +: DW] = b_pipe[gi];
  end

`ifdef SA_SEQ_PERF_EN
  // Saturating performance counters, restarted by each accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else if (start_acc) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (busy && (perf_busy_cyc != '1))
        perf_busy_cyc <= perf_busy_cyc + 1'b1;
      if ((state_q == S_FEED) && !in_valid && (perf_stall_cyc != '1))
        perf_stall_cyc <= perf_stall_cyc + 1'b1;
    end
  end
`else
  // Performance counters not built: no extra ports or state.
`endif

endmodule

// File: tb/tb_sa_seq.sv
// tb_sa_seq: scoreboard bench for sa_seq. A behavioural output-stationary
// array model sits on sa_a/sa_b/sa_rst. The driver pushes each job's
// hand-computed C matrix and latency into a queue; a monitor pops an entry
// on every done pulse and compares.

module tb_sa_seq;

  localparam int N      = 8;
  localparam int DW     = 8;
  localparam int KW     = 8;
  localparam int PE_LAT = 1;

  logic            clk;
  logic            rst;
  logic            start;
  logic [KW-1:0]   k_len;
  logic            busy;
  logic            done;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] a_col;
  logic [N*DW-1:0] b_row;
  logic            sa_rst;
  logic [N*DW-1:0] sa_a;
  logic [N*DW-1:0] sa_b;
`ifdef SA_SEQ_PERF_EN
  logic [31:0]     perf_busy_cyc;
  logic [31:0]     perf_stall_cyc;
`endif

  sa_seq #(.N(N), .DW(DW), .KW(KW), .PE_LAT(PE_LAT)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .k_len          (k_len),
    .busy           (busy),
    .done           (done),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .a_col          (a_col),
    .b_row          (b_row),
    .sa_rst         (sa_rst),
    .sa_a           (sa_a),
    .sa_b           (sa_b)
`ifdef SA_SEQ_PERF_EN
    ,
    .perf_busy_cyc  (perf_busy_cyc),
    .perf_stall_cyc (perf_stall_cyc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural systolic array ----------------
  // a moves right, b moves down, one register per PE; the accumulator adds
  // the product of the operands present at its inputs.
  logic [31:0]            acc   [N][N];
  logic signed [DW-1:0]   a_fwd [N][N];
  logic signed [DW-1:0]   b_fwd [N][N];
  logic signed [DW-1:0]   a_in, b_in;
  logic signed [31:0]     prod;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j == 0) a_in = sa_a[i*DW +: DW];
        else        a_in = a_fwd[i][j-1];
        if (i == 0) b_in = sa_b[j*DW +: DW];
        else        b_in = b_fwd[i-1][j];
        prod = a_in * b_in;
        if (!sa_rst) begin
          acc[i][j]   <= '0;
          a_fwd[i][j] <= '0;
          b_fwd[i][j] <= '0;
        end else begin
          acc[i][j]   <= acc[i][j] + prod;
          a_fwd[i][j] <= a_in;
          b_fwd[i][j] <= b_in;
        end
      end
    end
  end

  // ---------------- job data ----------------
  // kind 0: 3x3 example, kind 1: every operand 127, kind 2: empty job.
  int a_tab [3][3] = '{'{1, 4, 7}, '{2, 5, 8}, '{3, 6, 9}};           // A[i][k]
  int b_col [3][3] = '{'{10, 11, 12}, '{13, 14, 15}, '{16, 17, 18}};  // B[k][j] = b_col[j][k]
  // Hand-computed C = A*B for the 3x3 example.
  int c_tab [3][3] = '{'{138, 174, 210}, '{171, 216, 261}, '{204, 258, 312}};

  function automatic logic [N*DW-1:0] step_a(input int kind, input int k);
    logic [N*DW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      if (kind == 0 && i < 3) v[i*DW +: DW] = DW'(a_tab[i][k]);
      if (kind == 1)          v[i*DW +: DW] = 8'd127;
    end
    return v;
  endfunction

  function automatic logic [N*DW-1:0] step_b(input int kind, input int k);
    logic [N*DW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) begin
      if (kind == 0 && j < 3) v[j*DW +: DW] = DW'(b_col[j][k]);
      if (kind == 1)          v[j*DW +: DW] = 8'd127;
    end
    return v;
  endfunction

  function automatic logic [N*N*32-1:0] exp_c(input int kind, input int c_all);
    logic [N*N*32-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        if (kind == 0 && i < 3 && j < 3) v[(i*N+j)*32 +: 32] = 32'(c_tab[i][j]);
        if (kind == 1)                   v[(i*N+j)*32 +: 32] = 32'(c_all);
      end
    return v;
  endfunction

  typedef struct packed {
    logic [31:0]       start_cyc;
    logic [31:0]       lat;
    logic [31:0]       stall;
    logic [N*N*32-1:0] c;
  } exp_t;

  exp_t sb [$];

  // ---------------- monitor ----------------
  exp_t hold_e;
  bit   hold_pend = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      hold_pend <= 1'b0;
    end else begin
      if (hold_pend) begin
        // One cycle after done: busy drops, C still readable.
        check("busy_after_done", 64'(busy), 64'd0);
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            check($sformatf("c_hold[%0d][%0d]", i, j), 64'(acc[i][j]),
                  64'(hold_e.c[(i*N+j)*32 +: 32]));
        hold_pend <= 1'b0;
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_latency", 64'(cyc - int'(e.start_cyc)), 64'(e.lat));
          check("busy_in_done", 64'(busy), 64'd1);
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
              check($sformatf("c[%0d][%0d]", i, j), 64'(acc[i][j]),
                    64'(e.c[(i*N+j)*32 +: 32]));
`ifdef SA_SEQ_PERF_EN
          check("perf_stall_cyc", 64'(perf_stall_cyc), 64'(e.stall));
          check("perf_busy_cyc", 64'(perf_busy_cyc), 64'(e.lat - 1));
`endif
          hold_e    <= e;
          hold_pend <= 1'b1;
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Runs one job. Bubbles: bub_n cycles with in_valid low once bub_after
  // steps are accepted. poke pulses start during FEED and DRAIN. Junk with
  // in_valid high is driven whenever in_ready is low and must be ignored.
  task automatic run_job(input int k, input int kind, input int bub_after,
                         input int bub_n, input bit poke, input int c_all);
    exp_t e;
    int   idx;
    int   bub_left;
    int   guard;
    @(negedge clk);
    start    = 1'b1;
    k_len    = KW'(k);
    in_valid = 1'b1;
    a_col    = {$urandom, $urandom};
    b_row    = {$urandom, $urandom};
    e.start_cyc = 32'(cyc);
    e.lat       = (k == 0) ? 32'd2 : 32'(k + bub_n + 2*N - 2 + PE_LAT + 2);
    e.stall     = 32'(bub_n);
    e.c         = exp_c(kind, c_all);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    k_len = 8'd7;                       // mid-job change must have no effect
    idx      = 0;
    bub_left = bub_n;
    guard    = 0;
    while (idx < k && guard < 1000) begin
      start = 1'b0;
      if (in_ready) begin
        if (idx == bub_after && bub_left > 0) begin
          in_valid = 1'b0;
          a_col    = {$urandom, $urandom};
          b_row    = {$urandom, $urandom};
          bub_left--;
        end else begin
          in_valid = 1'b1;
          a_col    = step_a(kind, idx);
          b_row    = step_b(kind, idx);
          idx++;
          if (poke && idx == 2) start = 1'b1;
        end
      end else begin
        in_valid = 1'b1;
        a_col    = {$urandom, $urandom};
        b_row    = {$urandom, $urandom};
      end
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) check("feed_timeout", 64'd1, 64'd0);
    // First DRAIN cycle (or DONE for an empty job).
    in_valid = 1'b1;
    a_col    = {$urandom, $urandom};
    b_row    = {$urandom, $urandom};
    start    = poke;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!done && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 600) check("done_timeout", 64'd1, 64'd0);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    start    = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    k_len    = '0;
    in_valid = 1'b0;
    a_col    = '0;
    b_row    = '0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_busy",     64'(busy),     64'd0);
    check("rst_done",     64'(done),     64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_sa_rst",   64'(sa_rst),   64'd0);
    check("rst_sa_a",     64'(sa_a),     64'd0);
    check("rst_sa_b",     64'(sa_b),     64'd0);
    rst = 1'b1;
    idle(3);

    // Reset in the middle of FEED: no done may follow, outputs clear at once.
    @(negedge clk);
    start = 1'b1;
    k_len = 8'd5;
    @(negedge clk);                     // CLEAR
    start = 1'b0;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);                   // FEED, two steps accepted
      in_valid = 1'b1;
      a_col    = step_a(1, s);
      b_row    = step_b(1, s);
    end
    @(negedge clk);
    check("pre_rst_in_ready", 64'(in_ready), 64'd1);
    check("pre_rst_sa_a_lane0", 64'(sa_a[DW-1:0]), 64'd127);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst_busy",     64'(busy),     64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    check("midrst_sa_rst",   64'(sa_rst),   64'd0);
    check("midrst_sa_a",     64'(sa_a),     64'd0);
    check("midrst_sa_b",     64'(sa_b),     64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // 3x3 example, no bubbles.
    run_job(3, 0, 0, 0, 1'b0, 0);
    idle(4);
    // Same job with two bubbles after the first step.
    run_job(3, 0, 1, 2, 1'b0, 0);
    idle(3);
    // Empty job.
    run_job(0, 2, 0, 0, 1'b0, 0);
    idle(3);
    // Saturation-width checks: 4*16129 and 255*16129.
    run_job(4, 1, 0, 0, 1'b0, 64516);
    idle(2);
    run_job(255, 1, 0, 0, 1'b0, 4112895);
    idle(2);
    // start pokes in FEED/DRAIN, then back-to-back job right after done.
    run_job(3, 0, 0, 0, 1'b1, 0);
    run_job(4, 1, 0, 0, 1'b0, 64516);
    idle(6);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
